// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 scancodes, joystick bit
// positions, the DIP download index and the scancode-to-key decoder.
package arcade_input_pkg;

  localparam logic [7:0] SC_P1_UP     = 8'h75;
  localparam logic [7:0] SC_P1_DOWN   = 8'h72;
  localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
  localparam logic [7:0] SC_P1_FIRE0  = 8'h14;
  localparam logic [7:0] SC_P1_FIRE1  = 8'h11;
  localparam logic [7:0] SC_P1_FIRE2  = 8'h29;
  localparam logic [7:0] SC_P2_UP     = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P2_FIRE0  = 8'h1C;
  localparam logic [7:0] SC_P2_FIRE1  = 8'h1B;
  localparam logic [7:0] SC_P2_FIRE2  = 8'h15;
  localparam logic [7:0] SC_START1_A  = 8'h05;
  localparam logic [7:0] SC_START1_B  = 8'h16;
  localparam logic [7:0] SC_START2_A  = 8'h06;
  localparam logic [7:0] SC_START2_B  = 8'h1E;
  localparam logic [7:0] SC_COIN_A    = 8'h76;
  localparam logic [7:0] SC_COIN_B    = 8'h2E;
  localparam logic [7:0] SC_COIN_C    = 8'h36;

  localparam int JB_RIGHT = 0;
  localparam int JB_LEFT  = 1;
  localparam int JB_UP    = 2;
  localparam int JB_DOWN  = 3;
  localparam int JB_FIRE0 = 4;

  localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;

  // Per-player keys are laid out up, down, left, right, fire0..fire2
  localparam int KEYS_PER_PLAYER = 7;
  localparam int NKEYS           = 21;

  typedef enum logic [4:0] {
    K_P1_UP, K_P1_DOWN, K_P1_LEFT, K_P1_RIGHT, K_P1_FIRE0, K_P1_FIRE1, K_P1_FIRE2,
    K_P2_UP, K_P2_DOWN, K_P2_LEFT, K_P2_RIGHT, K_P2_FIRE0, K_P2_FIRE1, K_P2_FIRE2,
    K_START1_A, K_START1_B, K_START2_A, K_START2_B,
    K_COIN_A, K_COIN_B, K_COIN_C
  } key_id_e;

  function automatic logic [NKEYS-1:0] key_decode(input logic [7:0] sc);
    logic [NKEYS-1:0] hit;
    hit = '0;
    case (sc)
      SC_P1_UP:    hit[K_P1_UP]    = 1'b1;
      SC_P1_DOWN:  hit[K_P1_DOWN]  = 1'b1;
      SC_P1_LEFT:  hit[K_P1_LEFT]  = 1'b1;
      SC_P1_RIGHT: hit[K_P1_RIGHT] = 1'b1;
      SC_P1_FIRE0: hit[K_P1_FIRE0] = 1'b1;
      SC_P1_FIRE1: hit[K_P1_FIRE1] = 1'b1;
      SC_P1_FIRE2: hit[K_P1_FIRE2] = 1'b1;
      SC_P2_UP:    hit[K_P2_UP]    = 1'b1;
      SC_P2_DOWN:  hit[K_P2_DOWN]  = 1'b1;
      SC_P2_LEFT:  hit[K_P2_LEFT]  = 1'b1;
      SC_P2_RIGHT: hit[K_P2_RIGHT] = 1'b1;
      SC_P2_FIRE0: hit[K_P2_FIRE0] = 1'b1;
      SC_P2_FIRE1: hit[K_P2_FIRE1] = 1'b1;
      SC_P2_FIRE2: hit[K_P2_FIRE2] = 1'b1;
      SC_START1_A: hit[K_START1_A] = 1'b1;
      SC_START1_B: hit[K_START1_B] = 1'b1;
      SC_START2_A: hit[K_START2_A] = 1'b1;
      SC_START2_B: hit[K_START2_B] = 1'b1;
      SC_COIN_A:   hit[K_COIN_A]   = 1'b1;
      SC_COIN_B:   hit[K_COIN_B]   = 1'b1;
      SC_COIN_C:   hit[K_COIN_C]   = 1'b1;
      default:     hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/coin_stretch.sv
// Coin pulse stretcher: a rising edge of the raw coin loads a down-counter,
// and the registered output stays high while raw coin or the counter is live.
module coin_stretch #(
  parameter logic [15:0] MIN = 16'd2400
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw_i,
  output logic coin_o
);

  logic        raw_q;
  logic [15:0] cnt_q, cnt_d;
  logic        coin_q;

  always_comb begin
    cnt_d = cnt_q;
    if (raw_i && !raw_q) begin
      cnt_d = MIN;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Output looks at the next count so the pulse lasts exactly MIN clocks
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      raw_q  <= 1'b0;
      cnt_q  <= 16'd0;
      coin_q <= 1'b0;
    end else begin
      raw_q  <= raw_i;
      cnt_q  <= cnt_d;
      coin_q <= raw_i | (cnt_d != 16'd0);
    end
  end

  assign coin_o = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input front-end: keyboard, joysticks and DIP download merged into
// registered player buses. Define INPUT_AUTOFIRE_EN to build the autofire gate.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          PLAYERS   = 2,
  parameter int          NBTN      = 1,
  parameter int          DIP_BYTES = 8,
  parameter int          MERGE     = 1,
  parameter int          START_BIT = 5,
  parameter int          COIN_BIT  = 7,
  parameter logic [15:0] COIN_MIN  = 16'd2400,
  parameter logic [19:0] AF_HALF   = 20'd400000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [PLAYERS*16-1:0]     joy_in,
  input  logic                      ioctl_wr,
  input  logic [7:0]                ioctl_index,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  input  logic [PLAYERS-1:0]        autofire,
  output logic [PLAYERS*4-1:0]      dir,
  output logic [PLAYERS*NBTN-1:0]   fire,
  output logic [1:0]                start,
  output logic                      coin,
  output logic [DIP_BYTES*8-1:0]    dip
);

  logic                    key_tog_q;
  logic [NKEYS-1:0]        key_q;
  logic [NKEYS-1:0]        key_hit;
  logic                    kb_event;

  logic [PLAYERS*4-1:0]    pl_dir;
  logic [PLAYERS*NBTN-1:0] pl_fire;
  logic [PLAYERS*4-1:0]    dir_q, dir_d;
  logic [PLAYERS*NBTN-1:0] fire_q, fire_d;
  logic [1:0]              start_q, start_d;
  logic [DIP_BYTES*8-1:0]  dip_q;
  logic [3:0]              dir_any;
  logic [NBTN-1:0]         fire_any;
  logic                    js_start1, js_start2, js_coin, coin_raw;

  assign kb_event = ps2_key[10] ^ key_tog_q;
  assign key_hit  = key_decode(ps2_key[7:0]);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_tog_q <= 1'b0;
      key_q     <= '0;
    end else begin
      key_tog_q <= ps2_key[10];
      if (kb_event) begin
        for (int i = 0; i < NKEYS; i++) begin
          if (key_hit[i]) key_q[i] <= ps2_key[9];
        end
      end
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]      kb_dir;
    logic [NBTN-1:0] kb_fire;

    if (p < 2) begin : g_kb
      localparam int B = p * KEYS_PER_PLAYER;
      assign kb_dir  = {key_q[B], key_q[B+1], key_q[B+2], key_q[B+3]};
      assign kb_fire = key_q[B+4 +: NBTN];
    end else begin : g_nokb
      assign kb_dir  = 4'd0;
      assign kb_fire = '0;
    end

    assign pl_dir[4*p +: 4] = {joy_in[16*p+JB_UP],   joy_in[16*p+JB_DOWN],
                               joy_in[16*p+JB_LEFT], joy_in[16*p+JB_RIGHT]} | kb_dir;
    assign pl_fire[NBTN*p +: NBTN] = joy_in[16*p+JB_FIRE0 +: NBTN] | kb_fire;
  end

`ifdef INPUT_AUTOFIRE_EN
  logic [19:0] af_cnt_q;
  logic        af_wave_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt_q  <= 20'd0;
      af_wave_q <= 1'b0;
    end else if (af_cnt_q == AF_HALF - 20'd1) begin
      af_cnt_q  <= 20'd0;
      af_wave_q <= ~af_wave_q;
    end else begin
      af_cnt_q  <= af_cnt_q + 20'd1;
    end
  end
`endif

  always_comb begin
    dir_any   = 4'd0;
    fire_any  = '0;
    js_start1 = 1'b0;
    js_start2 = 1'b0;
    js_coin   = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      dir_any   = dir_any  | pl_dir[4*p +: 4];
      fire_any  = fire_any | pl_fire[NBTN*p +: NBTN];
      js_start1 = js_start1 | joy_in[16*p+START_BIT];
      js_start2 = js_start2 | joy_in[16*p+START_BIT+1];
      js_coin   = js_coin   | joy_in[16*p+COIN_BIT];
    end

    dir_d  = pl_dir;
    fire_d = pl_fire;
    if (MERGE != 0) begin
      for (int p = 0; p < PLAYERS; p++) begin
        dir_d[4*p +: 4]        = dir_any;
        fire_d[NBTN*p +: NBTN] = fire_any;
      end
    end
`ifdef INPUT_AUTOFIRE_EN
    for (int p = 0; p < PLAYERS; p++) begin
      if (autofire[p]) fire_d[NBTN*p] = fire_d[NBTN*p] & af_wave_q;
    end
`endif

    start_d  = {key_q[K_START2_A] | key_q[K_START2_B] | js_start2,
                key_q[K_START1_A] | key_q[K_START1_B] | js_start1};
    coin_raw = key_q[K_COIN_A] | key_q[K_COIN_B] | key_q[K_COIN_C] | js_coin;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dir_q   <= '0;
      fire_q  <= '0;
      start_q <= 2'd0;
    end else begin
      dir_q   <= dir_d;
      fire_q  <= fire_d;
      start_q <= start_d;
    end
  end

  // Addresses at or above DIP_BYTES match no byte and fall through
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_q <= '0;
    end else if (ioctl_wr && ioctl_index == DIP_IOCTL_INDEX) begin
      for (int k = 0; k < DIP_BYTES; k++) begin
        if (ioctl_addr == 25'(k)) dip_q[8*k +: 8] <= ioctl_dout;
      end
    end
  end

  coin_stretch #(.MIN(COIN_MIN)) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw_i   (coin_raw),
    .coin_o  (coin)
  );

  assign dir   = dir_q;
  assign fire  = fire_q;
  assign start = start_q;
  assign dip   = dip_q;

  logic unused_ok;
  assign unused_ok = ^{ps2_key[8], joy_in, autofire, key_q, AF_HALF};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench: two mapper instances (independent and merged players)
// driven from one stimulus sequence, checked against hand-computed values.
module tb_arcade_input_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [1:0]  autofire;

  logic [7:0]  dir0, dir1;
  logic [3:0]  fire0, fire1;
  logic [1:0]  start0, start1;
  logic        coin0, coin1;
  logic [63:0] dip0, dip1;

  int   n_vec = 0;
  int   n_err = 0;
  logic tog = 1'b0;
  logic [20:0] hist;
  logic [15:0] af_hist;
  int   ones, bad;

  always #5 clk = ~clk;

  arcade_input_mapper #(
    .PLAYERS(2), .NBTN(2), .DIP_BYTES(8), .MERGE(0),
    .COIN_MIN(16'd10), .AF_HALF(20'd4)
  ) dut0 (
    .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .joy_in(joy_in),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .autofire(autofire),
    .dir(dir0), .fire(fire0), .start(start0), .coin(coin0), .dip(dip0)
  );

  arcade_input_mapper #(
    .PLAYERS(2), .NBTN(2), .DIP_BYTES(8), .MERGE(1),
    .COIN_MIN(16'd10), .AF_HALF(20'd4)
  ) dut1 (
    .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .joy_in(joy_in),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .autofire(autofire),
    .dir(dir1), .fire(fire1), .start(start1), .coin(coin1), .dip(dip1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic kb(input logic pressed, input logic ext, input logic [7:0] sc);
    tog = ~tog;
    ps2_key = {tog, pressed, ext, sc};
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ps2_key = '0; joy_in = '0; autofire = '0;
    ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    ticks(2);
    check("reset_dir",  {dir1, dir0}, 64'h0);
    check("reset_misc", {fire1, fire0, start1, start0, coin1, coin0}, 64'h0);
    check("reset_dip",  dip0, 64'h0);
    rst = 1'b0;
    tick();

    // Keyboard: P1 up, two-clock latency
    kb(1'b1, 1'b0, 8'h75);
    tick();
    check("kb_up_lat1", dir0, 64'h00);
    tick();
    check("kb_up_dir0", dir0, 64'h08);
    check("kb_up_dir1", dir1, 64'h88);
    kb(1'b0, 1'b0, 8'h75);
    ticks(2);
    check("kb_up_clear", dir0, 64'h00);

    // Extended flag is ignored: E0 6B still means P1 left
    kb(1'b1, 1'b1, 8'h6B);
    ticks(2);
    check("kb_ext_left", dir0, 64'h02);
    kb(1'b0, 1'b1, 8'h6B);
    ticks(2);

    // P2 right
    kb(1'b1, 1'b0, 8'h34);
    ticks(2);
    check("kb_p2_right0", dir0, 64'h10);
    check("kb_p2_right1", dir1, 64'h11);
    kb(1'b0, 1'b0, 8'h34);
    ticks(2);

    // Space is fire2, beyond NBTN=2: ignored
    kb(1'b1, 1'b0, 8'h29);
    ticks(2);
    check("kb_fire2_ignored", {fire1, fire0}, 64'h00);
    kb(1'b0, 1'b0, 8'h29);
    ticks(2);

    // LAlt is P1 fire1
    kb(1'b1, 1'b0, 8'h11);
    ticks(2);
    check("kb_fire1_0", fire0, 64'h2);
    check("kb_fire1_1", fire1, 64'hA);
    kb(1'b0, 1'b0, 8'h11);
    ticks(2);

    // Joystick: P2 fire0 and P2 up, one-clock latency
    joy_in = 32'h0014_0000;
    tick();
    check("joy_fire0", fire0, 64'h4);
    check("joy_fire1", fire1, 64'h5);
    check("joy_dir0",  dir0,  64'h80);
    check("joy_dir1",  dir1,  64'h88);
    joy_in = 32'h0020_0040;
    tick();
    check("joy_start", start0, 64'h3);
    joy_in = '0;
    tick();
    check("joy_start_clr", start0, 64'h0);

    kb(1'b1, 1'b0, 8'h1E);
    ticks(2);
    check("kb_start2", start0, 64'h2);
    kb(1'b0, 1'b0, 8'h1E);
    ticks(2);

    // Keyboard event and joystick change in the same cycle
    kb(1'b1, 1'b0, 8'h74);
    joy_in = 32'h0000_0002;
    tick();
    check("same_cyc_1", dir0, 64'h02);
    tick();
    check("same_cyc_2", dir0, 64'h03);
    kb(1'b0, 1'b0, 8'h74);
    joy_in = '0;
    tick();
    check("same_cyc_3", dir0, 64'h01);
    tick();
    check("same_cyc_4", dir0, 64'h00);

    // Coin: raw high 3 clocks, COIN_MIN=10 -> high 10 clocks
    hist = '0;
    joy_in = 32'h80;
    for (int i = 1; i <= 20; i++) begin
      tick();
      hist[i] = coin0;
      if (i == 3) joy_in = '0;
    end
    check("coin_single", hist, 64'h0007FE);

    // Second rising edge 5 clocks after the first extends to 15 clocks
    hist = '0;
    joy_in = 32'h80;
    for (int i = 1; i <= 20; i++) begin
      tick();
      hist[i] = coin0;
      if (i == 3) joy_in = '0;
      if (i == 5) joy_in = 32'h80;
      if (i == 6) joy_in = '0;
    end
    check("coin_retrigger", hist, 64'h00FFFE);

    // DIP download: addresses 0..9, only 0..7 land
    ioctl_wr = 1'b1;
    ioctl_index = 8'd254;
    for (int a = 0; a < 10; a++) begin
      ioctl_addr = 25'(a);
      ioctl_dout = 8'hA0 + 8'(a);
      tick();
      if (a == 0) check("dip_latency", dip0, 64'h0000_0000_0000_00A0);
    end
    ioctl_index = 8'd253;
    ioctl_addr  = 25'd1;
    ioctl_dout  = 8'hFF;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("dip_bank", dip0, 64'hA7A6_A5A4_A3A2_A1A0);

    // Autofire on P1 fire0 held from the joystick
    autofire = 2'b01;
    joy_in = 32'h10;
    tick();
    af_hist = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      af_hist[i] = fire0[0];
    end
    ones = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) ones += int'(af_hist[i]);
`ifdef INPUT_AUTOFIRE_EN
    for (int i = 0; i < 12; i++) if (af_hist[i] === af_hist[i+4]) bad++;
    check("autofire_duty", 64'(ones), 64'd8);
    check("autofire_period", 64'(bad), 64'd0);
`else
    check("autofire_off", 64'(ones), 64'd16);
`endif
    autofire = 2'b00;
    joy_in = '0;
    ticks(2);

    // Reset mid-stretch with keys held
    kb(1'b1, 1'b0, 8'h75);
    tick();
    kb(1'b1, 1'b0, 8'h1C);
    tick();
    if (tog) kb(1'b0, 1'b0, 8'h00);
    joy_in = 32'h80;
    tick();
    joy_in = '0;
    ticks(2);
    check("pre_rst_dir",  dir0,  64'h08);
    check("pre_rst_fire", fire0, 64'h4);
    check("pre_rst_coin", coin0, 64'h1);
    rst = 1'b1;
    #1;
    check("rst_async_out", {dir1, dir0, fire1, fire0, start1, start0, coin1, coin0}, 64'h0);
    check("rst_async_dip", dip0, 64'h0);
    ticks(2);
    rst = 1'b0;
    ticks(2);
    check("post_rst_idle", {dir0, fire0, coin0}, 64'h0);
    kb(1'b1, 1'b0, 8'h6B);
    ticks(2);
    check("post_rst_kb", dir0, 64'h02);
    check("post_rst_coin", coin0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised input front-end for arcade cores: it turns HPS keyboard events, N joysticks and the DIP-switch download stream into registered per-player control, start, coin and DIP buses. It sits between `hps_io` and the game core in `emu`. It replaces the hand-written keyboard `casex`, the joystick OR-ing and the `sw[]` loader with one block that scales in players, fire buttons and DIP bytes. It adds two behaviours: a coin-pulse stretcher and optional autofire.

## Interface
Parameters:
- `PLAYERS`, 2: number of players and joystick inputs (1–4).
- `NBTN`, 1: fire buttons per player (1–3).
- `DIP_BYTES`, 8: depth of the DIP bank.
- `MERGE`, 1: 1 ORs all players' controls onto every player output; 0 keeps players independent.
- `START_BIT`, 5: joystick bit for start 1. Start 2 uses `START_BIT+1`.
- `COIN_BIT`, 7: joystick bit for coin.
- `COIN_MIN`, 16'd2400: minimum coin high time, in clocks.
- `AF_HALF`, 20'd400000: autofire half-period, in clocks.

Ports (reset is asynchronous and active-high):
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ps2_key` in 11: [10] toggles on each event, [9] pressed, [8] extended, [7:0] scancode.
- `joy_in` in PLAYERS*16: joystick words; player p occupies [16p+15:16p].
- `ioctl_wr` in 1; `ioctl_index` in 8; `ioctl_addr` in 25; `ioctl_dout` in 8: download stream.
- `autofire` in PLAYERS: per-player autofire enable.
- `dir` out PLAYERS*4: per player {up, down, left, right}.
- `fire` out PLAYERS*NBTN: fire buttons.
- `start` out 2: start 1 and start 2.
- `coin` out 1: stretched coin.
- `dip` out DIP_BYTES*8: DIP bank; byte k is at [8k+7:8k].

## Operation
- Keyboard edge detection: `ps2_key[10]` is registered; an event is an inequality between the new and registered value. On an event, the key register selected by scancode takes `ps2_key[9]`. Bit [8] is ignored.
- Player 1 keys: arrows 75/72/6B/74; fire LCtrl 14, LAlt 11, Space 29.
- Player 2 keys: R/F/D/G 2D/2B/23/34; fire A/S/Q 1C/1B/15.
- Start 1 is F1 05 or `1` 16. Start 2 is F2 06 or `2` 1E. Coin is Esc 76, `5` 2E or `6` 36.
- Fire keys with index ≥ `NBTN` and players ≥ `PLAYERS` are ignored.
- Joystick mapping: bits [0]=R, [1]=L, [2]=U, [3]=D; [4+k]=fire k. Start and coin are the OR over all joysticks of `START_BIT`, `START_BIT+1` and `COIN_BIT`.
- Player value is keyboard OR joystick. When `MERGE`=1, every player output carries the OR across all players.
- Coin stretcher: on a rising edge of raw coin, load a 16-bit counter with `COIN_MIN`. `coin` is high while raw coin is high or the counter is nonzero. The counter decrements to 0 and saturates there. A new rising edge while counting reloads it.
- DIP loader: when `ioctl_wr` && `ioctl_index`==254 && `ioctl_addr` < `DIP_BYTES`, write `ioctl_dout` to byte `ioctl_addr`. Writes at or above `DIP_BYTES` are dropped.
- Reset clears every key register, counter and DIP byte to 0. The top level therefore must not assert `reset` during a DIP download.

## Timing
- Every output is registered and resets to 0.
- Keyboard latency: a `ps2_key` toggle reaches the outputs 2 clocks later (edge register, then output register).
- Joystick latency: 1 clock.
- DIP latency: a write appears on `dip` 1 clock later.
- Coin: goes high 1 clock after raw coin, and falls at max(raw fall, edge + `COIN_MIN`) + 1.
- A keyboard event and a joystick change in the same cycle are both honoured.
- Reset asserted mid-stretch or mid-download aborts immediately; the first event after release is detected normally.

## Configuration
- `INPUT_AUTOFIRE_EN` defined: a 20-bit free-running counter toggles a square wave every `AF_HALF` clocks. For player p, while `autofire[p]` is high, fire 0 is ANDed with that square wave.
- Not defined: the `autofire` port is ignored, no counter is synthesised, and fire 0 passes through unchanged.

## Structure
- Package `arcade_input_pkg`: scancode localparams, joystick bit indices (`JB_RIGHT`…`JB_FIRE0`) and the DIP ioctl index 254.
- Sub-module `coin_stretch`: counter plus edge detector, parameter `MIN`. One instance.
- The per-player mapping is a generate loop.

## Test plan
- Toggle `ps2_key`={1,1,0,0x75}: player 1 up appears on `dir[3]` 2 clocks later. Toggle with [9]=0: up clears.
- `MERGE`=0, `joy_in[16+4]`=1: `fire[NBTN]` goes high and `fire[0]` stays 0. With `MERGE`=1 both are high.
- Raw coin high for 3 clocks, `COIN_MIN`=10: `coin` is high for 10 clocks. A second edge at clock 5 extends it to clock 15.
- Writes at `ioctl_index`=254, addr 0..9, `DIP_BYTES`=8: bytes 0–7 are loaded, addr 8 and 9 are dropped, and index 253 writes are ignored.
- `INPUT_AUTOFIRE_EN`, `AF_HALF`=4, fire held with `autofire[0]`=1: `fire[0]` toggles every 4 clocks. Without the macro it stays high.
- Assert `reset` mid-stretch with keys held: all outputs go to 0 at once, and the next `ps2_key` toggle after release is decoded.
